// File: rtl/nfc_mif_wr_pkg.sv
// Shared definitions for the write-direction memory interface:
// bus width, FSM state encodings and ECC parity lengths.
package nfc_mif_wr_pkg;

   localparam int unsigned DAT_WID_DEF = 16;

   typedef enum logic [1:0] {
      MIF_WR_IDLE = 2'b00,
      MIF_WR_DAT  = 2'b01,
      MIF_WR_SPA  = 2'b10,
      MIF_WR_ECC  = 2'b11
   } mif_wr_state_e;

   localparam logic [4:0] ECC_LEN_18 = 5'd18;
   localparam logic [4:0] ECC_LEN_25 = 5'd25;

   function automatic logic [4:0] ecc_par_len(input logic [1:0] len_code);
      logic [4:0] len;
      case (len_code)
         2'b01:   len = ECC_LEN_18;
         2'b10:   len = ECC_LEN_25;
         default: len = 5'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/nfc_mif_wr_seg.sv
// Segment length select for the current FSM state and last-byte detect.
module nfc_mif_wr_seg
   import nfc_mif_wr_pkg::*;
(
   input  mif_wr_state_e state_i,
   input  logic [11:0]   blk_cnt_i,
   input  logic [11:0]   blk_len_i,
   input  logic [3:0]    spa_len_i,
   input  logic [1:0]    ecc_len_i,
   output logic          seg_last_o
);

   logic [12:0] seg_len;

   always_comb begin
      seg_len    = '0;
      seg_last_o = 1'b0;
      case (state_i)
         // A zero block length is treated as a full 4096-byte block.
         MIF_WR_DAT: seg_len = (blk_len_i == 12'd0) ? 13'd4096 : {1'b0, blk_len_i};
         MIF_WR_SPA: seg_len = {9'd0, spa_len_i};
         MIF_WR_ECC: seg_len = {8'd0, ecc_par_len(ecc_len_i)};
         default:    seg_len = '0;
      endcase
      seg_last_o = (seg_len != 13'd0) && ({1'b0, blk_cnt_i} == (seg_len - 13'd1));
   end

endmodule

// File: rtl/nfc_mif_wr.sv
// Flash->RAM memory interface: stores data/spare bytes into the 16-bit
// buffer RAM and forwards data, spare and parity bytes to the ECC decoder.
module nfc_mif_wr
   import nfc_mif_wr_pkg::*;
#(
   parameter int unsigned DAT_WID = DAT_WID_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               nfc_dat_en,
   input  logic               nfc_dat_dir,
   input  logic [11:0]        nfc_blk_len,
   input  logic [3:0]         nfc_spa_len,
   input  logic               nfc_spa_en,
   input  logic               nfc_ecc_en,
   input  logic [1:0]         nfc_ecc_len,
   input  logic [13:0]        nfc_trn_cnt,
   input  logic [13:0]        nfc_dat_addr,
   input  logic [13:0]        nfc_spa_addr,
   input  logic               nfif_data_wr,
   input  logic [DAT_WID-1:0] nfif_data_out,
   output logic               nfif_wr_rdy,
   input  logic               ecc_dec_rdy,
   output logic               mif_ecc_wr,
   output logic [7:0]         mif_ecc_dat,
   output logic               mif_ecc_par,
   output logic               mif_blk_done,
   output logic               mif_wr_done,
   output logic [12:0]        nfc_ram_addr,
   output logic               nfc_ram_cen,
   output logic [1:0]         nfc_ram_wen,
   output logic [15:0]        nfc_ram_din
);

   mif_wr_state_e state_q, state_d;
   logic [13:0]   dat_ptr_q, dat_ptr_d;
   logic [13:0]   spa_ptr_q, spa_ptr_d;
   logic [11:0]   blk_cnt_q, blk_cnt_d;
   logic [13:0]   tot_cnt_q, tot_cnt_d;
   logic          blk_done_d, wr_done_d;
   logic          acc, seg_last, tot_last, eob, spa_go, ecc_go;
   logic [13:0]   act_ptr;
   logic [7:0]    byte_in;
   logic          unused_hi;

   assign byte_in   = nfif_data_out[7:0];
   assign unused_hi = ^nfif_data_out[DAT_WID-1:8];

   assign nfif_wr_rdy = (state_q != MIF_WR_IDLE) & (ecc_dec_rdy | ~nfc_ecc_en);
   assign acc         = nfif_data_wr & nfif_wr_rdy;
   assign spa_go      = nfc_spa_en & (nfc_spa_len != 4'd0);
   assign ecc_go      = nfc_ecc_en & ((nfc_ecc_len == 2'b01) | (nfc_ecc_len == 2'b10));
   assign tot_last    = (tot_cnt_q == (nfc_trn_cnt - 14'd1));
   assign act_ptr     = (state_q == MIF_WR_SPA) ? spa_ptr_q : dat_ptr_q;

   nfc_mif_wr_seg u_seg (
      .state_i    (state_q),
      .blk_cnt_i  (blk_cnt_q),
      .blk_len_i  (nfc_blk_len),
      .spa_len_i  (nfc_spa_len),
      .ecc_len_i  (nfc_ecc_len),
      .seg_last_o (seg_last)
   );

   always_comb begin
      state_d    = state_q;
      dat_ptr_d  = dat_ptr_q;
      spa_ptr_d  = spa_ptr_q;
      blk_cnt_d  = blk_cnt_q;
      tot_cnt_d  = tot_cnt_q;
      blk_done_d = 1'b0;
      wr_done_d  = 1'b0;
      eob        = 1'b0;
      if (state_q == MIF_WR_IDLE) begin
         if (nfc_dat_en && !nfc_dat_dir && (nfc_trn_cnt != 14'd0)) begin
            state_d   = MIF_WR_DAT;
            dat_ptr_d = nfc_dat_addr;
            spa_ptr_d = nfc_spa_addr;
            blk_cnt_d = '0;
            tot_cnt_d = '0;
         end
      end else begin
         if (acc) begin
            tot_cnt_d = tot_cnt_q + 14'd1;
            blk_cnt_d = blk_cnt_q + 12'd1;
            if (state_q == MIF_WR_DAT) dat_ptr_d = dat_ptr_q + 14'd1;
            if (state_q == MIF_WR_SPA) spa_ptr_d = spa_ptr_q + 14'd1;
            if (seg_last) begin
               blk_cnt_d = '0;
               case (state_q)
                  MIF_WR_DAT: begin
                     if (spa_go)      state_d = MIF_WR_SPA;
                     else if (ecc_go) state_d = MIF_WR_ECC;
                     else             eob     = 1'b1;
                  end
                  MIF_WR_SPA: begin
                     if (ecc_go) state_d = MIF_WR_ECC;
                     else        eob     = 1'b1;
                  end
                  default: eob = 1'b1;
               endcase
            end
            if (eob) begin
               blk_done_d = 1'b1;
               state_d    = MIF_WR_DAT;
            end
            // Transfer end wins over any segment transition, even mid-segment.
            if (tot_last) begin
               state_d   = MIF_WR_IDLE;
               wr_done_d = 1'b1;
            end
         end
         if (!nfc_dat_en) state_d = MIF_WR_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= MIF_WR_IDLE;
         dat_ptr_q    <= '0;
         spa_ptr_q    <= '0;
         blk_cnt_q    <= '0;
         tot_cnt_q    <= '0;
         mif_ecc_wr   <= 1'b0;
         mif_ecc_dat  <= '0;
         mif_ecc_par  <= 1'b0;
         mif_blk_done <= 1'b0;
         mif_wr_done  <= 1'b0;
         nfc_ram_addr <= '0;
         nfc_ram_cen  <= 1'b1;
         nfc_ram_wen  <= 2'b11;
         nfc_ram_din  <= '0;
      end else begin
         state_q      <= state_d;
         dat_ptr_q    <= dat_ptr_d;
         spa_ptr_q    <= spa_ptr_d;
         blk_cnt_q    <= blk_cnt_d;
         tot_cnt_q    <= tot_cnt_d;
         mif_blk_done <= blk_done_d;
         mif_wr_done  <= wr_done_d;
         mif_ecc_wr   <= acc & nfc_ecc_en;
         if (acc) begin
            mif_ecc_dat <= byte_in;
            mif_ecc_par <= (state_q == MIF_WR_ECC);
         end
         if (acc && ((state_q == MIF_WR_DAT) || (state_q == MIF_WR_SPA))) begin
            nfc_ram_cen  <= 1'b0;
            nfc_ram_addr <= act_ptr[13:1];
            nfc_ram_din  <= {byte_in, byte_in};
            nfc_ram_wen  <= act_ptr[0] ? 2'b01 : 2'b10;
         end else begin
            nfc_ram_cen <= 1'b1;
            nfc_ram_wen <= 2'b11;
         end
      end
   end

endmodule
